// File: rtl/id_pipe_stage_if.sv
// Bus bundle between the IF/ID stage, the writeback/debug ports and the ID/EX register.
// Clock and reset remain plain ports on id_pipe_stage.
interface id_pipe_stage_if #(
   parameter int NB_DATA = 32,
   parameter int NB_PC   = 32,
   parameter int NB_REG  = 5
);
   logic                i_enable;
   logic                i_valid;
   logic [31:0]         i_inst;
   logic [NB_PC-1:0]    i_pc;
   logic                i_flush;
   logic                i_wb_write;
   logic [NB_REG-1:0]   i_wb_addr;
   logic [NB_DATA-1:0]  i_wb_data;
   logic [NB_REG-1:0]   i_dbg_addr;

   logic [NB_DATA-1:0]  o_dbg_data;
   logic                o_stall;
   logic                o_redirect;
   logic [NB_PC-1:0]    o_redirect_addr;
   logic                o_valid;
   logic [NB_PC-1:0]    o_pc;
   logic [NB_DATA-1:0]  o_data_a;
   logic [NB_DATA-1:0]  o_data_b;
   logic [NB_DATA-1:0]  o_imm;
   logic [NB_DATA-1:0]  o_shamt;
   logic [NB_REG-1:0]   o_rs;
   logic [NB_REG-1:0]   o_rt;
   logic [NB_REG-1:0]   o_dest;
   logic [7:0]          o_ctrl;
   logic                o_halted;

   modport master (
      output i_enable, i_valid, i_inst, i_pc, i_flush,
             i_wb_write, i_wb_addr, i_wb_data, i_dbg_addr,
      input  o_dbg_data, o_stall, o_redirect, o_redirect_addr, o_valid, o_pc,
             o_data_a, o_data_b, o_imm, o_shamt, o_rs, o_rt, o_dest, o_ctrl, o_halted
   );

   modport slave (
      input  i_enable, i_valid, i_inst, i_pc, i_flush,
             i_wb_write, i_wb_addr, i_wb_data, i_dbg_addr,
      output o_dbg_data, o_stall, o_redirect, o_redirect_addr, o_valid, o_pc,
             o_data_a, o_data_b, o_imm, o_shamt, o_rs, o_rt, o_dest, o_ctrl, o_halted
   );
endinterface

// File: rtl/id_pipe_stage.sv
// Instruction decode stage: register file with write-before-read bypass, decoder,
// load-use stall, jump redirect and the ID/EX pipeline register with sticky halt.
//
// state   | meaning
// ST_RUN  | decoding normally
// ST_HALT | a hlt was loaded into ID/EX; every later slot is a bubble until reset
module id_pipe_stage #(
   parameter int NB_DATA   = 32,
   parameter int NB_PC     = 32,
   parameter int NB_REG    = 5,
   parameter int HAZARD_EN = 1
) (
   input logic            i_clock,
   input logic            i_reset,
   id_pipe_stage_if.slave bus
);
   localparam int DEPTH = 2 ** NB_REG;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_HLT   = 6'h3F;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;

   localparam int C_REG_WRITE = 0;
   localparam int C_MEM_READ  = 1;
   localparam int C_MEM_WRITE = 2;
   localparam int C_BRANCH    = 3;
   localparam int C_ALU_SRC   = 4;
   localparam int C_JUMP      = 5;
   localparam int C_JR        = 6;
   localparam int C_HLT       = 7;

   typedef enum logic {ST_RUN, ST_HALT} state_t;
   state_t state, state_nxt;

   logic [NB_DATA-1:0] regs [DEPTH];

   logic [5:0]         op, funct;
   logic [NB_REG-1:0]  rs, rt, rd;
   logic [4:0]         shamt;
   logic [15:0]        imm16;
   logic [NB_DATA-1:0] rs_data, rt_data;
   logic [7:0]         ctrl;
   logic [NB_REG-1:0]  dest;
   logic               reads_rt, is_jump, is_jreg;
   logic               wb_fire, load_use, stall, halted, bubble, load_hlt;

   assign op    = bus.i_inst[31:26];
   assign rs    = NB_REG'(bus.i_inst[25:21]);
   assign rt    = NB_REG'(bus.i_inst[20:16]);
   assign rd    = NB_REG'(bus.i_inst[15:11]);
   assign shamt = bus.i_inst[10:6];
   assign funct = bus.i_inst[5:0];
   assign imm16 = bus.i_inst[15:0];

   assign wb_fire = bus.i_wb_write && bus.i_enable && (bus.i_wb_addr != '0);

   // A write landing this cycle is visible to every read port in the same cycle.
   function automatic logic [NB_DATA-1:0] read_port(input logic [NB_REG-1:0] addr);
      if (addr == '0)
         return '0;
      if (wb_fire && (bus.i_wb_addr == addr))
         return bus.i_wb_data;
      return regs[addr];
   endfunction

   always_comb begin
      rs_data        = read_port(rs);
      rt_data        = read_port(rt);
      bus.o_dbg_data = read_port(bus.i_dbg_addr);
   end

   always_comb begin
      ctrl     = '0;
      dest     = '0;
      reads_rt = 1'b0;
      is_jump  = 1'b0;
      is_jreg  = 1'b0;
      case (op)
         OP_RTYPE: begin
            if (funct == FN_JR) begin
               ctrl[C_JR] = 1'b1;
               is_jreg    = 1'b1;
            end else if (funct == FN_JALR) begin
               ctrl[C_JR]        = 1'b1;
               ctrl[C_REG_WRITE] = 1'b1;
               dest              = rd;
               is_jreg           = 1'b1;
            end else begin
               ctrl[C_REG_WRITE] = 1'b1;
               dest              = rd;
               reads_rt          = 1'b1;
            end
         end
         OP_LW: begin
            ctrl[C_REG_WRITE] = 1'b1;
            ctrl[C_MEM_READ]  = 1'b1;
            ctrl[C_ALU_SRC]   = 1'b1;
            dest              = rt;
         end
         OP_SW: begin
            ctrl[C_MEM_WRITE] = 1'b1;
            ctrl[C_ALU_SRC]   = 1'b1;
            reads_rt          = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            ctrl[C_BRANCH] = 1'b1;
            reads_rt       = 1'b1;
         end
         OP_J: begin
            ctrl[C_JUMP] = 1'b1;
            is_jump      = 1'b1;
         end
         OP_JAL: begin
            ctrl[C_JUMP]      = 1'b1;
            ctrl[C_REG_WRITE] = 1'b1;
            dest              = NB_REG'(31);
            is_jump           = 1'b1;
         end
         OP_HLT: ctrl[C_HLT] = 1'b1;
         default: begin
            ctrl[C_REG_WRITE] = 1'b1;
            ctrl[C_ALU_SRC]   = 1'b1;
            dest              = rt;
         end
      endcase
   end

   assign halted   = (state == ST_HALT);
   assign load_use = (HAZARD_EN != 0) && bus.i_valid && bus.o_valid && bus.o_ctrl[C_MEM_READ]
                     && (bus.o_dest != '0)
                     && ((bus.o_dest == rs) || ((bus.o_dest == rt) && reads_rt));
   // Flush discards the dependent instruction, so holding IF would be pointless.
   assign stall    = load_use && !bus.i_flush && !halted;
   assign bubble   = bus.i_flush || !bus.i_valid || stall || halted;
   assign load_hlt = !bubble && (op == OP_HLT);

   assign bus.o_stall         = stall;
   assign bus.o_halted        = halted;
   assign bus.o_redirect      = bus.i_valid && bus.i_enable && !stall && !bus.i_flush && !halted
                                && (is_jump || is_jreg);
   assign bus.o_redirect_addr = is_jreg ? NB_PC'(rs_data)
                                        : {bus.i_pc[NB_PC-1:26], bus.i_inst[25:0]};

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:  if (bus.i_enable && load_hlt) state_nxt = ST_HALT;
         ST_HALT: state_nxt = ST_HALT;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset)
         state <= ST_RUN;
      else
         state <= state_nxt;
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= '0;
      end else if (wb_fire) begin
         regs[bus.i_wb_addr] <= bus.i_wb_data;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         bus.o_valid  <= 1'b0;
         bus.o_pc     <= '0;
         bus.o_data_a <= '0;
         bus.o_data_b <= '0;
         bus.o_imm    <= '0;
         bus.o_shamt  <= '0;
         bus.o_rs     <= '0;
         bus.o_rt     <= '0;
         bus.o_dest   <= '0;
         bus.o_ctrl   <= '0;
      end else if (bus.i_enable) begin
         if (bubble) begin
            bus.o_valid  <= 1'b0;
            bus.o_pc     <= '0;
            bus.o_data_a <= '0;
            bus.o_data_b <= '0;
            bus.o_imm    <= '0;
            bus.o_shamt  <= '0;
            bus.o_rs     <= '0;
            bus.o_rt     <= '0;
            bus.o_dest   <= '0;
            bus.o_ctrl   <= '0;
         end else begin
            bus.o_valid  <= 1'b1;
            bus.o_pc     <= bus.i_pc;
            bus.o_data_a <= rs_data;
            bus.o_data_b <= rt_data;
            bus.o_imm    <= {{(NB_DATA-16){imm16[15]}}, imm16};
            bus.o_shamt  <= NB_DATA'(shamt);
            bus.o_rs     <= rs;
            bus.o_rt     <= rt;
            bus.o_dest   <= dest;
            bus.o_ctrl   <= ctrl;
         end
      end
   end
endmodule

// File: tb/tb_id_pipe_stage.sv
// Bench for id_pipe_stage: directed scenarios with literal expectations, then random
// traffic compared every cycle against an instruction-class reference model.
module tb_id_pipe_stage;
   localparam int NB_DATA = 32;
   localparam int NB_PC   = 32;
   localparam int NB_REG  = 5;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   bit   in_rst = 1'b0;

   id_pipe_stage_if #(.NB_DATA(NB_DATA), .NB_PC(NB_PC), .NB_REG(NB_REG)) bus ();

   id_pipe_stage #(.NB_DATA(NB_DATA), .NB_PC(NB_PC), .NB_REG(NB_REG), .HAZARD_EN(1)) dut (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   typedef enum int {K_R, K_JR, K_JALR, K_LW, K_SW, K_BR, K_J, K_JAL, K_HLT, K_ALUI} kind_t;

   typedef struct packed {
      logic        v;
      logic [31:0] pc, a, b, imm, shamt;
      logic [4:0]  rs, rt, dest;
      logic [7:0]  ctrl;
   } rec_t;

   logic [31:0] m_rf [32];
   bit          m_halt = 1'b0;
   rec_t        m_out;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic kind_t kind_of(input logic [31:0] ins);
      case (ins[31:26])
         6'h00:        return (ins[5:0] == 6'h08) ? K_JR : (ins[5:0] == 6'h09) ? K_JALR : K_R;
         6'h23:        return K_LW;
         6'h2B:        return K_SW;
         6'h04, 6'h05: return K_BR;
         6'h02:        return K_J;
         6'h03:        return K_JAL;
         6'h3F:        return K_HLT;
         default:      return K_ALUI;
      endcase
   endfunction

   // bits: hlt jr jump alu_src branch mem_write mem_read reg_write
   function automatic logic [7:0] ctrl_of(input kind_t k);
      case (k)
         K_R:     return 8'b0000_0001;
         K_JR:    return 8'b0100_0000;
         K_JALR:  return 8'b0100_0001;
         K_LW:    return 8'b0001_0011;
         K_SW:    return 8'b0001_0100;
         K_BR:    return 8'b0000_1000;
         K_J:     return 8'b0010_0000;
         K_JAL:   return 8'b0010_0001;
         K_HLT:   return 8'b1000_0000;
         default: return 8'b0001_0001;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (bus.i_wb_write && bus.i_enable && bus.i_wb_addr == a) return bus.i_wb_data;
      return m_rf[a];
   endfunction

   function automatic void model_comb(output bit stall, output bit redir,
                                      output logic [31:0] raddr, output rec_t nxt);
      logic [31:0] ins;
      kind_t       k;
      logic [4:0]  rs, rt, rd;
      bit          rt_used, hz;
      ins = bus.i_inst;
      k   = kind_of(ins);
      rs  = ins[25:21];
      rt  = ins[20:16];
      rd  = ins[15:11];
      rt_used = (k == K_R) || (k == K_SW) || (k == K_BR);
      hz = bus.i_valid && m_out.v && m_out.ctrl[1] && (m_out.dest != 5'd0)
           && ((m_out.dest == rs) || (m_out.dest == rt && rt_used));
      stall = hz && !bus.i_flush && !m_halt;
      redir = bus.i_valid && bus.i_enable && !stall && !bus.i_flush && !m_halt
              && (k inside {K_J, K_JAL, K_JR, K_JALR});
      raddr = (k == K_J || k == K_JAL) ? {bus.i_pc[31:26], ins[25:0]} : m_read(rs);
      nxt = '0;
      if (bus.i_valid && !bus.i_flush && !stall && !m_halt) begin
         nxt.v     = 1'b1;
         nxt.pc    = bus.i_pc;
         nxt.a     = m_read(rs);
         nxt.b     = m_read(rt);
         nxt.imm   = {{16{ins[15]}}, ins[15:0]};
         nxt.shamt = {27'd0, ins[10:6]};
         nxt.rs    = rs;
         nxt.rt    = rt;
         nxt.ctrl  = ctrl_of(k);
         case (k)
            K_R, K_JALR:  nxt.dest = rd;
            K_JAL:        nxt.dest = 5'd31;
            K_LW, K_ALUI: nxt.dest = rt;
            default:      nxt.dest = 5'd0;
         endcase
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin : model_seq
      bit          s, r;
      logic [31:0] ra;
      rec_t        n;
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) m_rf[i] <= 32'd0;
         m_out  <= '0;
         m_halt <= 1'b0;
      end else if (bus.i_enable) begin
         model_comb(s, r, ra, n);
         if (bus.i_wb_write && bus.i_wb_addr != 5'd0) m_rf[bus.i_wb_addr] <= bus.i_wb_data;
         m_out <= n;
         if (n.v && n.ctrl[7]) m_halt <= 1'b1;
      end
   end

   always @(negedge clk) begin : compare
      bit          s, r;
      logic [31:0] ra;
      rec_t        n;
      model_comb(s, r, ra, n);
      chk("stall", bus.o_stall, s);
      chk("redirect", bus.o_redirect, r);
      if (r) chk("redirect_addr", bus.o_redirect_addr, ra);
      chk("dbg_data", bus.o_dbg_data, m_read(bus.i_dbg_addr));
      chk("valid", bus.o_valid, m_out.v);
      chk("pc", bus.o_pc, m_out.pc);
      chk("data_a", bus.o_data_a, m_out.a);
      chk("data_b", bus.o_data_b, m_out.b);
      chk("imm", bus.o_imm, m_out.imm);
      chk("shamt", bus.o_shamt, m_out.shamt);
      chk("rs", bus.o_rs, m_out.rs);
      chk("rt", bus.o_rt, m_out.rt);
      chk("dest", bus.o_dest, m_out.dest);
      chk("ctrl", bus.o_ctrl, m_out.ctrl);
      chk("halted", bus.o_halted, m_halt);
   end

   function automatic logic [31:0] r_ins(input logic [4:0] s, t, d, input logic [5:0] fn);
      return {6'h00, s, t, d, 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] s, t,
                                         input logic [15:0] im);
      return {op, s, t, im};
   endfunction

   function automatic logic [31:0] rnd_inst();
      logic [4:0]  a, b, d;
      logic [15:0] im;
      a  = 5'($urandom_range(0, 7));
      b  = 5'($urandom_range(0, 7));
      d  = 5'($urandom_range(0, 7));
      im = 16'($urandom);
      case ($urandom_range(0, 11))
         0, 1:    return r_ins(a, b, d, 6'h20);
         2:       return r_ins(a, b, d, 6'h08);
         3:       return r_ins(a, b, d, 6'h09);
         4, 5:    return i_ins(6'h23, a, b, im);
         6:       return i_ins(6'h2B, a, b, im);
         7:       return i_ins(($urandom_range(0, 1) != 0) ? 6'h05 : 6'h04, a, b, im);
         8:       return {(($urandom_range(0, 1) != 0) ? 6'h03 : 6'h02), 26'($urandom)};
         9:       return i_ins(6'h08, a, b, im);
         10:      return $urandom;
         default: return ($urandom_range(0, 5) == 0) ? 32'hFC00_0000 : r_ins(a, b, d, 6'h22);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic v, input logic [31:0] ins, input logic [31:0] pc);
      bus.i_valid = v;
      bus.i_inst  = ins;
      bus.i_pc    = pc;
   endtask

   task automatic wbw(input logic [4:0] a, input logic [31:0] d);
      bus.i_wb_write = 1'b1;
      bus.i_wb_addr  = a;
      bus.i_wb_data  = d;
   endtask

   initial begin
      bus.i_enable   = 1'b1;
      bus.i_flush    = 1'b0;
      bus.i_wb_write = 1'b0;
      bus.i_wb_addr  = '0;
      bus.i_wb_data  = '0;
      bus.i_dbg_addr = 5'd5;
      put(1'b0, 32'd0, 32'd0);
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_valid", bus.o_valid, 0);
      chk("rst_ctrl", bus.o_ctrl, 0);
      chk("rst_halted", bus.o_halted, 0);
      chk("rst_dbg", bus.o_dbg_data, 0);
      tick();
      rst_n = 1'b1;
      wbw(5'd1, 32'h11); tick();
      wbw(5'd2, 32'h22); tick();
      bus.i_wb_write = 1'b0;

      // lw r5 then dependent add: one stall, one bubble, add issues after
      put(1'b1, i_ins(6'h23, 5'd1, 5'd5, 16'h0004), 32'h100); tick();
      chk("lw_valid", bus.o_valid, 1);
      chk("lw_dest", bus.o_dest, 5);
      chk("lw_ctrl", bus.o_ctrl, 8'h13);
      chk("lw_data_a", bus.o_data_a, 32'h11);
      put(1'b1, r_ins(5'd5, 5'd1, 5'd6, 6'h20), 32'h101);
      #2 chk("lu_stall", bus.o_stall, 1);
      tick();
      chk("lu_bubble", bus.o_valid, 0);
      #1 chk("lu_stall_clear", bus.o_stall, 0);
      tick();
      chk("lu_add_valid", bus.o_valid, 1);
      chk("lu_add_dest", bus.o_dest, 6);
      chk("lu_add_data_b", bus.o_data_b, 32'h11);

      // same-cycle writeback bypass, and r0 stays zero
      wbw(5'd3, 32'hDEAD_BEEF);
      bus.i_dbg_addr = 5'd3;
      put(1'b1, r_ins(5'd3, 5'd0, 5'd7, 6'h20), 32'h102);
      #2 chk("byp_dbg", bus.o_dbg_data, 32'hDEAD_BEEF);
      tick();
      chk("byp_data_a", bus.o_data_a, 32'hDEAD_BEEF);
      wbw(5'd0, 32'h1234);
      bus.i_dbg_addr = 5'd0;
      put(1'b1, r_ins(5'd0, 5'd3, 5'd7, 6'h20), 32'h103);
      #2 chk("r0_dbg", bus.o_dbg_data, 0);
      tick();
      chk("r0_data_a", bus.o_data_a, 0);
      chk("r3_data_b", bus.o_data_b, 32'hDEAD_BEEF);
      bus.i_wb_write = 1'b0;

      // jal redirect
      put(1'b1, {6'h03, 26'h000_0100}, 32'h4000_0008);
      #2;
      chk("jal_redirect", bus.o_redirect, 1);
      chk("jal_addr", bus.o_redirect_addr, 32'h4000_0100);
      tick();
      chk("jal_dest", bus.o_dest, 31);
      chk("jal_ctrl", bus.o_ctrl, 8'h21);

      // flush beats load-use
      put(1'b1, i_ins(6'h23, 5'd2, 5'd5, 16'h0000), 32'h104); tick();
      put(1'b1, r_ins(5'd5, 5'd1, 5'd6, 6'h20), 32'h105);
      bus.i_flush = 1'b1;
      #2 chk("flush_stall", bus.o_stall, 0);
      tick();
      chk("flush_bubble", bus.o_valid, 0);
      chk("flush_ctrl", bus.o_ctrl, 0);
      bus.i_flush = 1'b0;

      // freeze with pending writeback
      put(1'b1, i_ins(6'h08, 5'd1, 5'd2, 16'h0007), 32'h106); tick();
      chk("addi_dest", bus.o_dest, 2);
      bus.i_enable   = 1'b0;
      wbw(5'd9, 32'h55);
      bus.i_dbg_addr = 5'd9;
      put(1'b1, {6'h02, 26'h200}, 32'h107);
      repeat (3) begin
         #2;
         chk("frz_dbg", bus.o_dbg_data, 0);
         chk("frz_redirect", bus.o_redirect, 0);
         tick();
         chk("frz_dest", bus.o_dest, 2);
         chk("frz_imm", bus.o_imm, 7);
      end
      bus.i_enable = 1'b1;
      bus.i_valid  = 1'b0;
      #2 chk("resume_dbg_byp", bus.o_dbg_data, 32'h55);
      tick();
      bus.i_wb_write = 1'b0;
      #1 chk("resume_dbg", bus.o_dbg_data, 32'h55);

      // halt is sticky until reset
      put(1'b1, 32'hFC00_0000, 32'h108); tick();
      chk("hlt_ctrl", bus.o_ctrl, 8'h80);
      chk("hlt_halted", bus.o_halted, 1);
      put(1'b1, {6'h02, 26'h300}, 32'h109);
      #2 chk("hlt_redirect", bus.o_redirect, 0);
      tick();
      put(1'b1, r_ins(5'd2, 5'd1, 5'd6, 6'h20), 32'h10A); tick();
      chk("hlt_bubble", bus.o_valid, 0);
      chk("hlt_sticky", bus.o_halted, 1);
      rst_n = 1'b0;
      #2;
      chk("hlt_rst_halted", bus.o_halted, 0);
      chk("hlt_rst_dbg", bus.o_dbg_data, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_hlt_valid", bus.o_valid, 1);
      chk("post_hlt_dest", bus.o_dest, 6);

      // reset in the middle of a stall
      put(1'b1, i_ins(6'h23, 5'd1, 5'd5, 16'h0000), 32'h10B); tick();
      put(1'b1, r_ins(5'd5, 5'd1, 5'd6, 6'h20), 32'h10C);
      #2 chk("rs_stall", bus.o_stall, 1);
      rst_n = 1'b0;
      #1 chk("rs_stall_clr", bus.o_stall, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rs_add_dest", bus.o_dest, 6);

      for (int c = 0; c < 3000; c++) begin
         if (in_rst) begin
            rst_n  = 1'b1;
            in_rst = 1'b0;
         end else if ((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0) begin
            rst_n  = 1'b0;
            in_rst = 1'b1;
         end
         bus.i_enable   = ($urandom_range(0, 9) != 0);
         bus.i_valid    = ($urandom_range(0, 6) != 0);
         bus.i_flush    = ($urandom_range(0, 9) == 0);
         bus.i_inst     = rnd_inst();
         bus.i_pc       = $urandom;
         bus.i_wb_write = ($urandom_range(0, 1) != 0);
         bus.i_wb_addr  = 5'($urandom_range(0, 7));
         bus.i_wb_data  = $urandom;
         bus.i_dbg_addr = 5'($urandom_range(0, 7));
         tick();
      end

      rst_n = 1'b1;
      bus.i_valid = 1'b0;
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
